// File: rtl/multi_row_window_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_row_window_buffer_pkg
// Purpose  : Shared helpers for the multi-row window buffer and the MAC blocks
//            that consume its flattened tap bus.
//            - clog2_w : counter/index width, never narrower than 1 bit
//            - tap_lo  : LSB position of tap k within the flattened tap bus
// Revision : 1.0 - initial release
// ============================================================================
package multi_row_window_buffer_pkg;

    // Width of an index that can address n distinct values (minimum 1 bit).
    function automatic int clog2_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Tap k of a flattened bus occupies [tap_lo(k)+bw-1 : tap_lo(k)].
    function automatic int tap_lo(input int k, input int bw);
        return k * bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_row_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_row_window_buffer_if
// Purpose  : Pixel stream in / tap column out bundle of the window buffer.
//            master : pixel source (drives en, sof, rb_in)
//            slave  : window buffer (drives rb_out, out_valid, out_col,
//                     out_last)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_row_window_buffer_if
    import multi_row_window_buffer_pkg::*;
#(
    parameter int COLS      = 32,
    parameter int ROWS      = 5,
    parameter int BIT_WIDTH = 16
) ();

    logic                          en;
    logic                          sof;
    logic [BIT_WIDTH-1:0]          rb_in;
    logic [ROWS*BIT_WIDTH-1:0]     rb_out;
    logic                          out_valid;
    logic [clog2_w(COLS)-1:0]      out_col;
    logic                          out_last;

    modport master (
        output en, sof, rb_in,
        input  rb_out, out_valid, out_col, out_last
    );

    modport slave (
        input  en, sof, rb_in,
        output rb_out, out_valid, out_col, out_last
    );

endinterface
`default_nettype wire

// File: rtl/multi_row_window_buffer_row_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : row_delay_line
// Purpose  : Enable-gated shift line of COLS entries; o_dout is the value
//            shifted in COLS enabled cycles earlier. Synchronous clear.
// Ports    : clk, rst (sync, active-high), i_en (shift strobe),
//            i_din (entry value), o_dout (oldest entry)
// Revision : 1.0 - initial release
// ============================================================================
module row_delay_line #(
    parameter int COLS      = 32,
    parameter int BIT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_en,
    input  wire logic [BIT_WIDTH-1:0] i_din,
    output logic      [BIT_WIDTH-1:0] o_dout
);

    logic [BIT_WIDTH-1:0] r_mem [COLS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COLS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < COLS; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[COLS-1];

endmodule
`default_nettype wire

// File: rtl/multi_row_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_row_window_buffer
// Purpose  : N-row line buffer. Presents a vertically aligned column of ROWS
//            pixels (tap k = pixel accepted k*COLS accepts before the newest)
//            plus frame position, window-valid and last-column flags.
// Ports    : clk, rst (sync, active-high)
//            bus.slave : en, sof, rb_in in; rb_out, out_valid, out_col,
//                        out_last out
// Revision : 1.0 - initial release
// ============================================================================
module multi_row_window_buffer
    import multi_row_window_buffer_pkg::*;
#(
    parameter int COLS      = 32,
    parameter int ROWS      = 5,
    parameter int BIT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    multi_row_window_buffer_if.slave  bus
);

    localparam int c_col_w = clog2_w(COLS);
    localparam int c_row_w = clog2_w(ROWS);
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(COLS - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(ROWS - 1);

    logic [BIT_WIDTH-1:0]      r_tap0;
    logic [BIT_WIDTH-1:0]      w_tap [ROWS];
    logic [ROWS*BIT_WIDTH-1:0] w_rb_out;

    logic [c_col_w-1:0]        r_col_cnt;
    logic [c_row_w-1:0]        r_row_cnt;
    logic [c_col_w-1:0]        w_col_eff;
    logic [c_row_w-1:0]        w_row_eff;
    logic                      w_wrap;

    logic                      r_out_valid;
    logic [c_col_w-1:0]        r_out_col;
    logic                      r_out_last;

    assign w_tap[0] = r_tap0;

    // Each line is fed from the tap above it, so line k delays tap 0 by
    // k*COLS accepts in total.
    generate
        for (genvar k = 1; k < ROWS; k++) begin : g_line
            row_delay_line #(
                .COLS      (COLS),
                .BIT_WIDTH (BIT_WIDTH)
            ) u_line (
                .clk    (clk),
                .rst    (rst),
                .i_en   (bus.en),
                .i_din  (w_tap[k-1]),
                .o_dout (w_tap[k])
            );
        end
        for (genvar k = 0; k < ROWS; k++) begin : g_flat
            assign w_rb_out[tap_lo(k, BIT_WIDTH) +: BIT_WIDTH] = w_tap[k];
        end
    endgenerate

    // A start-of-frame pixel is position (0,0) regardless of the counters.
    always_comb begin
        w_col_eff = bus.sof ? '0 : r_col_cnt;
        w_row_eff = bus.sof ? '0 : r_row_cnt;
        w_wrap    = (w_col_eff == c_last_col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap0      <= '0;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.en) begin
                r_tap0      <= bus.rb_in;
                r_out_col   <= w_col_eff;
                r_out_last  <= w_wrap;
                r_out_valid <= (w_row_eff == c_last_row);
                r_col_cnt   <= w_wrap ? '0 : w_col_eff + c_col_w'(1);
                // Row count saturates: once the window is full it stays full.
                if (w_wrap && (w_row_eff != c_last_row)) begin
                    r_row_cnt <= w_row_eff + c_row_w'(1);
                end else begin
                    r_row_cnt <= w_row_eff;
                end
            end
        end
    end

    assign bus.rb_out    = w_rb_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_col   = r_out_col;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_multi_row_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_row_window_buffer
// Purpose  : Self-checking bench. DUT a: COLS=4 ROWS=3 BIT_WIDTH=8,
//            DUT b: COLS=5 ROWS=2 BIT_WIDTH=16, both driven with the same
//            en/sof/rst pattern and compared against a pixel-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_row_window_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_row_window_buffer_if #(.COLS(4), .ROWS(3), .BIT_WIDTH(8))  ifa ();
    multi_row_window_buffer_if #(.COLS(5), .ROWS(2), .BIT_WIDTH(16)) ifb ();

    multi_row_window_buffer #(.COLS(4), .ROWS(3), .BIT_WIDTH(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    multi_row_window_buffer #(.COLS(5), .ROWS(2), .BIT_WIDTH(16)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int total = 0;
    int bad   = 0;

    // Model state per DUT: every pixel accepted since the last reset, the
    // pixel's position inside the current frame, and the expected outputs.
    int   hist [2][0:4095];
    int   cnt  [2];
    int   fidx [2];
    logic ev   [2];
    int   ec   [2];
    logic el   [2];

    function automatic int cols_of(input int d); return (d == 0) ? 4 : 5;  endfunction
    function automatic int rows_of(input int d); return (d == 0) ? 3 : 2;  endfunction
    function automatic int bw_of  (input int d); return (d == 0) ? 8 : 16; endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_taps(input int d);
        logic [63:0] r = '0;
        for (int k = 0; k < rows_of(d); k++) begin
            int idx = cnt[d] - 1 - k * cols_of(d);
            int v   = (idx >= 0) ? hist[d][idx] : 0;
            r |= (64'(v) & ((64'd1 << bw_of(d)) - 64'd1)) << (k * bw_of(d));
        end
        return r;
    endfunction

    task automatic model_upd(input int d, input logic r, input logic e, input logic s, input int pix);
        if (r) begin
            cnt[d] = 0; fidx[d] = 0; ev[d] = 1'b0; ec[d] = 0; el[d] = 1'b0;
        end else if (e) begin
            if (s) fidx[d] = 0;
            if (cnt[d] < 4096) hist[d][cnt[d]] = pix;
            cnt[d]++;
            ec[d] = fidx[d] % cols_of(d);
            el[d] = (ec[d] == cols_of(d) - 1);
            ev[d] = (fidx[d] >= (rows_of(d) - 1) * cols_of(d));
            fidx[d]++;
        end else begin
            ev[d] = 1'b0;
        end
    endtask

    // One clock: drive, let the edge happen, update the model, then compare.
    task automatic cyc(input logic r, input logic e, input logic s,
                       input logic [7:0] pa, input logic [15:0] pb);
        rst = r;
        ifa.en = e; ifa.sof = s; ifa.rb_in = pa;
        ifb.en = e; ifb.sof = s; ifb.rb_in = pb;
        @(posedge clk);
        model_upd(0, r, e, s, int'(pa));
        model_upd(1, r, e, s, int'(pb));
        #1;
        if (cnt[0] > 4096) begin
            check("model_depth", 64'(cnt[0]), 64'd4096);
            cnt[0] = 0; cnt[1] = 0;
        end
        check("a_taps",  64'(ifa.rb_out),    exp_taps(0));
        check("a_valid", 64'(ifa.out_valid), 64'(ev[0]));
        check("a_col",   64'(ifa.out_col),   64'(ec[0]));
        check("a_last",  64'(ifa.out_last),  64'(el[0]));
        check("b_taps",  64'(ifb.rb_out),    exp_taps(1));
        check("b_valid", 64'(ifb.out_valid), 64'(ev[1]));
        check("b_col",   64'(ifb.out_col),   64'(ec[1]));
        check("b_last",  64'(ifb.out_last),  64'(el[1]));
    endtask

    initial begin
        ifa.en = 1'b0; ifa.sof = 1'b0; ifa.rb_in = '0;
        ifb.en = 1'b0; ifb.sof = 1'b0; ifb.rb_in = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 8'hAA, 16'hBBBB);
        check("reset_taps", 64'(ifa.rb_out), 64'd0);

        // Continuous stream 1..16, sof on pixel 1
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, (i == 1), 8'(i), 16'(16'h1000 + i - 1));
            if (i <= 8) check("s1_early_valid", 64'(ifa.out_valid), 64'd0);
            if (i == 6) begin
                check("b_first_valid", 64'(ifb.out_valid), 64'd1);
                check("b_first_taps",  64'(ifb.rb_out), 64'h1000_1005);
            end
            if (i == 9) begin
                check("s1_p9_valid", 64'(ifa.out_valid), 64'd1);
                check("s1_p9_col",   64'(ifa.out_col), 64'd0);
                check("s1_p9_taps",  64'(ifa.rb_out), 64'h01_05_09);
            end
            if (i == 12) begin
                check("s1_p12_taps", 64'(ifa.rb_out), 64'h04_08_0c);
                check("s1_p12_last", 64'(ifa.out_last), 64'd1);
            end
        end

        // Same stream with two idle cycles after each pixel
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, (i == 1), 8'(i), 16'(16'h1000 + i - 1));
            cyc(0, 0, 1, 8'hEE, 16'hEEEE);
            cyc(0, 0, 0, 8'hDD, 16'hDDDD);
            check("s2_idle_valid", 64'(ifa.out_valid), 64'd0);
            if (i == 9) check("s2_p9_taps", 64'(ifa.rb_out), 64'h01_05_09);
        end

        // sof reissued with pixel 100 after pixel 10
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) cyc(0, 1, (i == 1), 8'(i), 16'(i));
        for (int i = 100; i <= 108; i++) begin
            cyc(0, 1, (i == 100), 8'(i), 16'(i));
            if (i <= 107) check("s3_masked_valid", 64'(ifa.out_valid), 64'd0);
            if (i == 108) begin
                check("s3_p108_valid", 64'(ifa.out_valid), 64'd1);
                check("s3_p108_col",   64'(ifa.out_col), 64'd0);
                check("s3_p108_taps",  64'(ifa.rb_out), {40'd0, 8'd100, 8'd104, 8'd108});
            end
        end

        // rst with en=1 mid-row after pixel 6, then refill from 20
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cyc(0, 1, (i == 1), 8'(i), 16'(i));
        cyc(1, 1, 0, 8'd7, 16'd7);
        check("s4_rst_taps", 64'(ifa.rb_out), 64'd0);
        check("s4_rst_col",  64'(ifa.out_col), 64'd0);
        for (int i = 20; i <= 28; i++) begin
            cyc(0, 1, 0, 8'(i), 16'(i));
            check("s4_refill_valid", 64'(ifa.out_valid), (i == 28) ? 64'd1 : 64'd0);
        end

        // 6-row frame: valid on every accept from pixel 9 through 24
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            cyc(0, 1, (i == 1), 8'(i), 16'(i));
            check("s5_valid", 64'(ifa.out_valid), (i >= 9) ? 64'd1 : 64'd0);
            check("s5_last",  64'(ifa.out_last), (i % 4 == 0) ? 64'd1 : 64'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic r, e, s;
            r = (($urandom % 100) == 0) || ((n % 512) == 0);
            e = (($urandom % 10) < 7);
            s = (($urandom % 40) == 0);
            cyc(r, e, s, 8'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
